// File: rtl/rr_pkg.sv
// Shared types and constants for the four-queue round-robin read scheduler.
package rr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_HOLD  = 2'd2
  } state_e;

  localparam int DATA_WIDTH_DEF = 10;
  localparam int NUM_QUEUES     = 4;
  localparam int IDX_W          = 2;

  function automatic logic [NUM_QUEUES-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    return 4'b0001 << idx;
  endfunction

endpackage

// File: rtl/rr_scheduler_4x1_pick.sv
// Rotating first-set finder: first asserted request scanning start, start+1, ... mod 4.
module rr_scheduler_4x1_pick
  import rr_pkg::*;
(
  input  logic [NUM_QUEUES-1:0] req,
  input  logic [IDX_W-1:0]      start,
  output logic [IDX_W-1:0]      winner,
  output logic                  found
);

  logic [NUM_QUEUES-1:0] rot_s;
  logic [IDX_W-1:0]      off_s;

  // Rotate so bit 0 is the start queue, then priority-encode the offset.
  always_comb begin
    rot_s = req;
    off_s = 2'd0;
    found = 1'b1;
    case (start)
      2'd0:    rot_s = req;
      2'd1:    rot_s = {req[0], req[3:1]};
      2'd2:    rot_s = {req[1:0], req[3:2]};
      2'd3:    rot_s = {req[2:0], req[3]};
      default: rot_s = req;
    endcase
    casez (rot_s)
      4'b???1: off_s = 2'd0;
      4'b??10: off_s = 2'd1;
      4'b?100: off_s = 2'd2;
      4'b1000: off_s = 2'd3;
      default: begin
        off_s = 2'd0;
        found = 1'b0;
      end
    endcase
    winner = start + off_s;
  end

endmodule

// File: rtl/rr_scheduler_4x1.sv
// Round-robin read scheduler: four FIFOs share one output path, bounded bursts,
// downstream almost_full pauses the grant without consuming burst credit.
module rr_scheduler_4x1
  import rr_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int BURST      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_QUEUES-1:0] fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_data_0,
  input  logic [DATA_WIDTH-1:0] fifo_data_1,
  input  logic [DATA_WIDTH-1:0] fifo_data_2,
  input  logic [DATA_WIDTH-1:0] fifo_data_3,
  input  logic                  almost_full,
  output logic [NUM_QUEUES-1:0] pop,
  output logic [IDX_W-1:0]      select,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out
);

  localparam logic [3:0] BURST_C = 4'(BURST);

  state_e          state_q, state_d;
  logic [IDX_W-1:0] g_q, g_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] select_q, select_d;
  logic             valid_q, valid_d;

  logic [IDX_W-1:0] start_s;
  logic [IDX_W-1:0] win_s;
  logic             found_s;
  logic             pop_en_s;
  logic [IDX_W-1:0] pop_idx_s;
  logic [DATA_WIDTH-1:0] mux_s;

  // Idle searches from the saved pointer; a release searches from the queue after g.
  assign start_s = (state_q == ST_IDLE) ? ptr_q : (g_q + 2'd1);

  rr_scheduler_4x1_pick u_pick (
    .req    (~fifo_empty),
    .start  (start_s),
    .winner (win_s),
    .found  (found_s)
  );

  // Next-state, burst accounting and pop decision.
  always_comb begin
    state_d   = state_q;
    g_d       = g_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    pop_en_s  = 1'b0;
    pop_idx_s = g_q;
    case (state_q)
      ST_IDLE: begin
        if (!almost_full && found_s) begin
          pop_en_s  = 1'b1;
          pop_idx_s = win_s;
          g_d       = win_s;
          cnt_d     = 4'd1;
          state_d   = ST_GRANT;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_GRANT, ST_HOLD: begin
        if (almost_full) begin
          state_d = ST_HOLD;
        end else if (!fifo_empty[g_q] && (cnt_q < BURST_C)) begin
          pop_en_s  = 1'b1;
          pop_idx_s = g_q;
          cnt_d     = cnt_q + 4'd1;
          state_d   = ST_GRANT;
        end else begin
          // Release without a bubble; g may win again if it is the only candidate.
          ptr_d = g_q + 2'd1;
          if (found_s) begin
            pop_en_s  = 1'b1;
            pop_idx_s = win_s;
            g_d       = win_s;
            cnt_d     = 4'd1;
            state_d   = ST_GRANT;
          end else begin
            state_d   = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output-register next values; select holds its last index when nothing is popped.
  always_comb begin
    valid_d = pop_en_s;
    if (pop_en_s) begin
      select_d = pop_idx_s;
    end else begin
      select_d = select_q;
    end
  end

  // Pop strobe is suppressed while reset is asserted so no word is lost at the clearing edge.
  always_comb begin
    if (reset && pop_en_s) begin
      pop = idx_to_onehot(pop_idx_s);
    end else begin
      pop = 4'b0000;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      g_q      <= 2'd0;
      cnt_q    <= 4'd0;
      ptr_q    <= 2'd0;
      select_q <= 2'd0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      select_q <= select_d;
      valid_q  <= valid_d;
    end
  end

  // Read-data mux steered by the registered select, zeroed when no word is in flight.
  always_comb begin
    case (select_q)
      2'd0:    mux_s = fifo_data_0;
      2'd1:    mux_s = fifo_data_1;
      2'd2:    mux_s = fifo_data_2;
      2'd3:    mux_s = fifo_data_3;
      default: mux_s = fifo_data_0;
    endcase
    if (valid_q) begin
      data_out = mux_s;
    end else begin
      data_out = {DATA_WIDTH{1'b0}};
    end
  end

  assign select    = select_q;
  assign valid_out = valid_q;

endmodule

// File: tb/tb_rr_scheduler_4x1.sv
// Directed bench for rr_scheduler_4x1 with a behavioural model of the four read FIFOs.
module tb_rr_scheduler_4x1;

  localparam int DW = 10;

  logic          clk;
  logic          reset;
  logic [3:0]    fifo_empty;
  logic [DW-1:0] fdata [0:3];
  logic          almost_full;
  logic [3:0]    pop;
  logic [1:0]    select;
  logic [DW-1:0] data_out;
  logic          valid_out;

  logic [DW-1:0] fq [0:3][$];

  logic [3:0]    pop_seen;
  logic [1:0]    select_seen;
  logic [DW-1:0] data_seen;
  logic          valid_seen;

  int tests_run;
  int tests_failed;

  rr_scheduler_4x1 #(.DATA_WIDTH(DW), .BURST(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .fifo_empty  (fifo_empty),
    .fifo_data_0 (fdata[0]),
    .fifo_data_1 (fdata[1]),
    .fifo_data_2 (fdata[2]),
    .fifo_data_3 (fdata[3]),
    .almost_full (almost_full),
    .pop         (pop),
    .select      (select),
    .data_out    (data_out),
    .valid_out   (valid_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic refresh_empty();
    for (int i = 0; i < 4; i++) fifo_empty[i] = (fq[i].size() == 0);
  endtask

  // Sample outputs at negedge, then let the FIFO model react to the pop after posedge.
  task automatic tick();
    @(negedge clk);
    pop_seen    = pop;
    select_seen = select;
    data_seen   = data_out;
    valid_seen  = valid_out;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (pop_seen[i]) begin
        tests_run++;
        if (fq[i].size() == 0) begin
          tests_failed++;
          $display("FAIL pop_on_empty fifo=%0d got=pop required=no_pop", i);
        end else begin
          fdata[i] = fq[i].pop_front();
        end
      end
    end
    refresh_empty();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      tests_run++;
      if ({pop_seen, valid_seen, select_seen, data_seen} !== {4'b0000, 1'b0, 2'd0, 10'd0}) begin
        tests_failed++;
        $display("FAIL reset_idle cyc=%0d got pop=%b v=%b sel=%0d d=%h required all zero",
                 c, pop_seen, valid_seen, select_seen, data_seen);
      end
    end
  endtask

  task automatic test_burst();
    int seq [24];
    int n [4];
    int k;
    logic [3:0]    exp_pop;
    logic [DW-1:0] exp_data;
    for (int q = 0; q < 4; q++) begin
      n[q] = 0;
      for (int j = 0; j < 6; j++) fq[q].push_back(10'(q * 256 + j));
    end
    refresh_empty();
    k = 0;
    for (int pass = 0; pass < 2; pass++)
      for (int q = 0; q < 4; q++)
        for (int r = 0; r < ((pass == 0) ? 4 : 2); r++) begin
          seq[k] = q;
          k++;
        end
    for (int c = 0; c < 26; c++) begin
      tick();
      exp_pop = (c < 24) ? (4'b0001 << seq[c]) : 4'b0000;
      tests_run++;
      if (pop_seen !== exp_pop) begin
        tests_failed++;
        $display("FAIL burst_pop cyc=%0d got=%b required=%b", c, pop_seen, exp_pop);
      end
      if (c > 0 && c <= 24) begin
        exp_data = 10'(seq[c-1] * 256 + n[seq[c-1]]);
        n[seq[c-1]]++;
        tests_run++;
        if ({valid_seen, select_seen, data_seen} !== {1'b1, 2'(seq[c-1]), exp_data}) begin
          tests_failed++;
          $display("FAIL burst_out cyc=%0d got v=%b sel=%0d d=%h required v=1 sel=%0d d=%h",
                   c, valid_seen, select_seen, data_seen, seq[c-1], exp_data);
        end
      end else if (c == 25) begin
        tests_run++;
        if ({valid_seen, data_seen} !== {1'b0, 10'd0}) begin
          tests_failed++;
          $display("FAIL burst_drain got v=%b d=%h required v=0 d=000", valid_seen, data_seen);
        end
      end
    end
  endtask

  task automatic test_single();
    logic [DW-1:0] words [3];
    words[0] = 10'h2A1; words[1] = 10'h2A2; words[2] = 10'h2A3;
    for (int j = 0; j < 3; j++) fq[2].push_back(words[j]);
    refresh_empty();
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++;
      if (pop_seen !== ((c < 3) ? 4'b0100 : 4'b0000)) begin
        tests_failed++;
        $display("FAIL single_pop cyc=%0d got=%b", c, pop_seen);
      end
      if (c >= 1 && c <= 3) begin
        tests_run++;
        if ({valid_seen, select_seen, data_seen} !== {1'b1, 2'd2, words[c-1]}) begin
          tests_failed++;
          $display("FAIL single_data cyc=%0d got v=%b sel=%0d d=%h required v=1 sel=2 d=%h",
                   c, valid_seen, select_seen, data_seen, words[c-1]);
        end
      end else if (c == 4) begin
        tests_run++;
        if (valid_seen !== 1'b0) begin
          tests_failed++;
          $display("FAIL single_idle got v=%b required v=0", valid_seen);
        end
      end
    end
  endtask

  task automatic test_almost_full();
    logic [3:0] exp_pop [11];
    logic [3:0] prev;
    exp_pop = '{4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010,
                4'b0010, 4'b0100, 4'b0100, 4'b0010, 4'b0000};
    for (int j = 0; j < 5; j++) fq[1].push_back(10'(16'h110 + j));
    for (int j = 0; j < 2; j++) fq[2].push_back(10'(16'h220 + j));
    refresh_empty();
    prev = 4'b0000;
    for (int c = 0; c < 11; c++) begin
      almost_full = (c >= 2 && c <= 4);
      tick();
      tests_run++;
      if (pop_seen !== exp_pop[c]) begin
        tests_failed++;
        $display("FAIL af_pop cyc=%0d got=%b required=%b", c, pop_seen, exp_pop[c]);
      end
      tests_run++;
      if (valid_seen !== (prev != 4'b0000)) begin
        tests_failed++;
        $display("FAIL af_valid cyc=%0d got=%b required=%b", c, valid_seen, (prev != 4'b0000));
      end
      prev = exp_pop[c];
    end
    almost_full = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] exp_pop [3];
    exp_pop = '{4'b1000, 4'b0001, 4'b0000};
    fq[3].push_back(10'h3C3);
    fq[0].push_back(10'h0C0);
    refresh_empty();
    for (int c = 0; c < 3; c++) begin
      tick();
      tests_run++;
      if (pop_seen !== exp_pop[c]) begin
        tests_failed++;
        $display("FAIL wrap_pop cyc=%0d got=%b required=%b", c, pop_seen, exp_pop[c]);
      end
    end
    tests_run++;
    if ({valid_seen, select_seen, data_seen} !== {1'b1, 2'd0, 10'h0C0}) begin
      tests_failed++;
      $display("FAIL wrap_data got v=%b sel=%0d d=%h required v=1 sel=0 d=0c0",
               valid_seen, select_seen, data_seen);
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] exp_pop [8];
    exp_pop = '{4'b0001, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000};
    for (int j = 0; j < 6; j++) fq[0].push_back(10'(16'h050 + j));
    refresh_empty();
    for (int c = 0; c < 8; c++) begin
      reset = (c == 1) ? 1'b0 : 1'b1;
      tick();
      tests_run++;
      if (pop_seen !== exp_pop[c]) begin
        tests_failed++;
        $display("FAIL rstmid_pop cyc=%0d got=%b required=%b", c, pop_seen, exp_pop[c]);
      end
      if (c == 2) begin
        tests_run++;
        if ({valid_seen, select_seen, data_seen} !== {1'b0, 2'd0, 10'd0}) begin
          tests_failed++;
          $display("FAIL rstmid_out got v=%b sel=%0d d=%h required v=0 sel=0 d=000",
                   valid_seen, select_seen, data_seen);
        end
      end
    end
    reset = 1'b1;
    tests_run++;
    if (fq[0].size() != 0) begin
      tests_failed++;
      $display("FAIL rstmid_left got=%0d words required=0", fq[0].size());
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset        = 1'b0;
    almost_full  = 1'b0;
    for (int i = 0; i < 4; i++) fdata[i] = 10'd0;
    refresh_empty();
    test_reset();
    test_burst();
    test_single();
    test_almost_full();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
